alu_op_scheduler: RTL and testbench
===================================

Name: alu_op_scheduler

Overview:
- Shares the four ALU sub-units (arithmetic, logic, compare, shift) between two requesters.
- Arbitrates round-robin and drives the operands and the one-hot unit enable for one cycle.
- Waits for the selected unit's done flag, then returns the result through a valid/ready response port.
- Sits between the instruction/control front end and the ALU sub-units.

Parameters:
DATA_W, 8, operand width (A, B)
OUT_W, 16, result width
TIMEOUT, 4, max cycles in WAIT for the unit flag before an error response

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, asynchronous, active-low
REQ0_VALID  in  1  requester 0 has an operation
REQ0_READY  out  1  requester 0 transfer accepted this cycle
REQ0_FUN  in  4  [3:2] unit select (00 arith, 01 logic, 10 cmp, 11 shift), [1:0] unit function
REQ0_A, REQ0_B  in  DATA_W  requester 0 operands
REQ1_VALID, REQ1_READY, REQ1_FUN, REQ1_A, REQ1_B  same as requester 0, for requester 1
ALU_A, ALU_B  out  DATA_W  operands to all units
ALU_FUN  out  2  function code to all units
ARITH_EN, LOGIC_EN, CMP_EN, SHIFT_EN  out  1  unit enables, at most one high
ARITH_OUT, LOGIC_OUT, CMP_OUT, SHIFT_OUT  in  OUT_W  unit results
ARITH_FLAG, LOGIC_FLAG, CMP_FLAG, SHIFT_FLAG  in  1  unit done flags
RSP_VALID  out  1  response available
RSP_READY  in  1  consumer accepts response
RSP_ID  out  1  requester the response belongs to
RSP_DATA  out  OUT_W  result
RSP_ERR  out  1  unit flag timeout

Behaviour:
- Reset (async, RST=0): state IDLE; last-grant pointer = 1, so REQ0 wins the first tie.
- Reset values: every output 0, including ALU_A/B/FUN, all enables and RSP_*.
- Reset mid-operation aborts immediately. No response is produced and no enable stays asserted.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE, grant selection:
  - Only one valid: grant it.
  - Both valid: grant the requester other than the last one granted.
  - REQn_READY = (state==IDLE) and grant==n, combinational, never both high.
- IDLE, transfer on VALID&READY:
  - Capture FUN, A and B into internal registers.
  - Record the ID and update the pointer to n.
  - Go to ISSUE.
- ISSUE (exactly 1 cycle):
  - ALU_A/B/FUN driven from the captured registers; these hold through WAIT.
  - The enable selected by FUN[3:2] is high; others are 0.
  - Go to WAIT and clear the timeout counter.
- WAIT:
  - All enables 0.
  - Each cycle, sample only the selected unit's FLAG.
  - Flag=1: register the selected unit's OUT into RSP_DATA, set RSP_ERR=0, go to RESP.
  - Otherwise increment the counter.
  - When the counter reaches TIMEOUT with no flag, set RSP_DATA=0 and RSP_ERR=1, then go to RESP.
  - Flags from non-selected units are ignored.
- RESP:
  - RSP_VALID=1; RSP_ID, RSP_DATA and RSP_ERR are stable while VALID=1 and READY=0.
  - On RSP_READY=1: next cycle RSP_VALID=0, go to IDLE.
  - No new request is accepted in RESP.
- Latency with units that register on the enable cycle:
  - Request accepted at edge t; ISSUE cycle t+1; flag seen in WAIT t+2; RSP_VALID from t+3.
  - Minimum 3 cycles from acceptance to response; one operation in flight at a time.
- Widths: the counter is $clog2(TIMEOUT+1) bits. Unit outputs pass through unmodified, with no truncation.
- A requester that drops VALID before READY is not granted; there is no penalty.
- Simultaneous RSP_READY and a new REQ_VALID in RESP: the new request is accepted at the earliest in the following IDLE cycle.

Test Plan:
- Single op: REQ0 FUN=4'b1101 (shift left A), A=8'h81; shift unit returns SHIFT_OUT=16'h0102 with flag the cycle after SHIFT_EN -> only SHIFT_EN pulses for 1 cycle with ALU_FUN=01; RSP_VALID 3 cycles after acceptance; RSP_DATA=16'h0102, ID=0, ERR=0.
- Round-robin: REQ0 and REQ1 held valid for 4 ops -> grants in order 0,1,0,1; RSP_ID sequence 0,1,0,1.
- Backpressure: RSP_READY=0 for 5 cycles -> RSP_VALID, DATA and ID held constant; both REQ_READY stay 0; RSP_READY=1 -> next cycle IDLE.
- Timeout: CMP op, CMP_FLAG never asserted (ARITH_FLAG pulsed as noise) -> after TIMEOUT=4 WAIT cycles, RSP_ERR=1, RSP_DATA=0.
- Reset mid-WAIT: RST low during WAIT -> all outputs 0 immediately; after release, REQ1 and REQ0 both valid -> REQ0 granted first.
- Enable exclusivity: random FUN over 200 ops -> never more than one *_EN high, each enable high exactly 1 cycle per op.

Source files
------------

// File: rtl/alu_op_scheduler.sv
// Round-robin scheduler sharing four ALU sub-units between two requesters.
// One operation in flight: IDLE (grant) -> ISSUE (enable pulse) -> WAIT (done flag) -> RESP.
module alu_op_scheduler #(
  parameter int DATA_W  = 8,
  parameter int OUT_W   = 16,
  parameter int TIMEOUT = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ0_VALID,
  output logic              REQ0_READY,
  input  logic [3:0]        REQ0_FUN,
  input  logic [DATA_W-1:0] REQ0_A,
  input  logic [DATA_W-1:0] REQ0_B,
  input  logic              REQ1_VALID,
  output logic              REQ1_READY,
  input  logic [3:0]        REQ1_FUN,
  input  logic [DATA_W-1:0] REQ1_A,
  input  logic [DATA_W-1:0] REQ1_B,
  output logic [DATA_W-1:0] ALU_A,
  output logic [DATA_W-1:0] ALU_B,
  output logic [1:0]        ALU_FUN,
  output logic              ARITH_EN,
  output logic              LOGIC_EN,
  output logic              CMP_EN,
  output logic              SHIFT_EN,
  input  logic [OUT_W-1:0]  ARITH_OUT,
  input  logic [OUT_W-1:0]  LOGIC_OUT,
  input  logic [OUT_W-1:0]  CMP_OUT,
  input  logic [OUT_W-1:0]  SHIFT_OUT,
  input  logic              ARITH_FLAG,
  input  logic              LOGIC_FLAG,
  input  logic              CMP_FLAG,
  input  logic              SHIFT_FLAG,
  output logic              RSP_VALID,
  input  logic              RSP_READY,
  output logic              RSP_ID,
  output logic [OUT_W-1:0]  RSP_DATA,
  output logic              RSP_ERR
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]              state_q, state_d;
  logic                    last_q, last_d;
  logic                    id_q, id_d;
  logic [3:0]              fun_q, fun_d;
  logic [DATA_W-1:0]       a_q, a_d, b_q, b_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d, cnt_inc;
  logic [OUT_W-1:0]        rsp_data_q, rsp_data_d;
  logic                    rsp_err_q, rsp_err_d;

  // Requester lanes packed so the grant can index them directly.
  logic [1:0]              req_vld;
  logic [1:0][3:0]         req_fun;
  logic [1:0][DATA_W-1:0]  req_a, req_b;
  logic                    gnt_vld, gnt_id, accept;

  assign req_vld = {REQ1_VALID, REQ0_VALID};
  assign req_fun = {REQ1_FUN, REQ0_FUN};
  assign req_a   = {REQ1_A, REQ0_A};
  assign req_b   = {REQ1_B, REQ0_B};

  always_comb begin
    gnt_vld = |req_vld;
    gnt_id  = 1'b0;
    case (req_vld)
      2'b10:   gnt_id = 1'b1;
      2'b11:   gnt_id = ~last_q;
      default: gnt_id = 1'b0;
    endcase
  end

  assign accept     = (state_q == S_IDLE) && gnt_vld;
  assign REQ0_READY = accept && !gnt_id;
  assign REQ1_READY = accept && gnt_id;

  // Unit lanes: index 0 arith, 1 logic, 2 cmp, 3 shift (matches FUN[3:2]).
  logic [3:0][OUT_W-1:0]   unit_out;
  logic [3:0]              unit_flag, unit_en;
  logic [1:0]              sel;

  assign unit_out  = {SHIFT_OUT, CMP_OUT, LOGIC_OUT, ARITH_OUT};
  assign unit_flag = {SHIFT_FLAG, CMP_FLAG, LOGIC_FLAG, ARITH_FLAG};
  assign sel       = fun_q[3:2];

  for (genvar g = 0; g < 4; g++) begin : g_unit
    assign unit_en[g] = (state_q == S_ISSUE) && (sel == 2'(g));
  end

  assign ARITH_EN = unit_en[0];
  assign LOGIC_EN = unit_en[1];
  assign CMP_EN   = unit_en[2];
  assign SHIFT_EN = unit_en[3];

  assign ALU_A     = a_q;
  assign ALU_B     = b_q;
  assign ALU_FUN   = fun_q[1:0];
  assign RSP_VALID = (state_q == S_RESP);
  assign RSP_ID    = id_q;
  assign RSP_DATA  = rsp_data_q;
  assign RSP_ERR   = rsp_err_q;

  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    id_d       = id_q;
    fun_d      = fun_q;
    a_d        = a_q;
    b_d        = b_q;
    cnt_d      = cnt_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          fun_d   = req_fun[gnt_id];
          a_d     = req_a[gnt_id];
          b_d     = req_b[gnt_id];
          id_d    = gnt_id;
          last_d  = gnt_id;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (unit_flag[sel]) begin
          rsp_data_d = unit_out[sel];
          rsp_err_d  = 1'b0;
          state_d    = S_RESP;
        end else if (cnt_inc == CNT_MAX) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          state_d    = S_RESP;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        if (RSP_READY) state_d = S_IDLE;
      end
    endcase
  end

  // Pointer resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= S_IDLE;
      last_q     <= 1'b1;
      id_q       <= 1'b0;
      fun_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      cnt_q      <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      id_q       <= id_d;
      fun_q      <= fun_d;
      a_q        <= a_d;
      b_q        <= b_d;
      cnt_q      <= cnt_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Directed bench for alu_op_scheduler with simple registered-flag unit stubs.
module tb_alu_op_scheduler;

  logic        CLK = 1'b0;
  logic        RST;
  logic        REQ0_VALID, REQ0_READY, REQ1_VALID, REQ1_READY;
  logic [3:0]  REQ0_FUN, REQ1_FUN;
  logic [7:0]  REQ0_A, REQ0_B, REQ1_A, REQ1_B;
  logic [7:0]  ALU_A, ALU_B;
  logic [1:0]  ALU_FUN;
  logic        ARITH_EN, LOGIC_EN, CMP_EN, SHIFT_EN;
  logic [15:0] ARITH_OUT, LOGIC_OUT, CMP_OUT, SHIFT_OUT;
  logic        ARITH_FLAG, LOGIC_FLAG, CMP_FLAG, SHIFT_FLAG;
  logic        RSP_VALID, RSP_READY, RSP_ID, RSP_ERR;
  logic [15:0] RSP_DATA;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  alu_op_scheduler #(.DATA_W(8), .OUT_W(16), .TIMEOUT(4)) dut (
    .CLK(CLK), .RST(RST),
    .REQ0_VALID(REQ0_VALID), .REQ0_READY(REQ0_READY), .REQ0_FUN(REQ0_FUN),
    .REQ0_A(REQ0_A), .REQ0_B(REQ0_B),
    .REQ1_VALID(REQ1_VALID), .REQ1_READY(REQ1_READY), .REQ1_FUN(REQ1_FUN),
    .REQ1_A(REQ1_A), .REQ1_B(REQ1_B),
    .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FUN(ALU_FUN),
    .ARITH_EN(ARITH_EN), .LOGIC_EN(LOGIC_EN), .CMP_EN(CMP_EN), .SHIFT_EN(SHIFT_EN),
    .ARITH_OUT(ARITH_OUT), .LOGIC_OUT(LOGIC_OUT), .CMP_OUT(CMP_OUT), .SHIFT_OUT(SHIFT_OUT),
    .ARITH_FLAG(ARITH_FLAG), .LOGIC_FLAG(LOGIC_FLAG), .CMP_FLAG(CMP_FLAG), .SHIFT_FLAG(SHIFT_FLAG),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_ID(RSP_ID),
    .RSP_DATA(RSP_DATA), .RSP_ERR(RSP_ERR)
  );

  // Unit stubs: distinct results per unit, done flag one cycle after the enable.
  logic fl_ar, fl_lo, fl_cm, fl_sh;
  logic fen_cmp = 1'b1;
  logic noise_ar = 1'b0;

  always @(posedge CLK) begin
    fl_ar <= ARITH_EN;
    fl_lo <= LOGIC_EN;
    fl_cm <= CMP_EN & fen_cmp;
    fl_sh <= SHIFT_EN;
  end

  assign ARITH_OUT  = {8'h00, ALU_A} + {8'h00, ALU_B};
  assign LOGIC_OUT  = {8'hA5, ALU_A & ALU_B};
  assign CMP_OUT    = {15'd0, ALU_A < ALU_B};
  assign SHIFT_OUT  = {8'h00, ALU_A} << 1;
  assign ARITH_FLAG = fl_ar | noise_ar;
  assign LOGIC_FLAG = fl_lo;
  assign CMP_FLAG   = fl_cm;
  assign SHIFT_FLAG = fl_sh;

  wire [3:0]  ens     = {ARITH_EN, LOGIC_EN, CMP_EN, SHIFT_EN};
  wire [1:0]  rdys    = {REQ1_READY, REQ0_READY};
  wire [42:0] all_out = {ALU_A, ALU_B, ALU_FUN, ens, RSP_VALID, RSP_ID, RSP_DATA, RSP_ERR, rdys};

  task automatic wait_accept(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (!ok) begin
        if (REQ0_READY || REQ1_READY) ok = 1'b1;
        else begin @(negedge CLK); #1; end
      end
    end
  endtask

  task automatic wait_rsp(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (!ok) begin
        if (RSP_VALID) ok = 1'b1;
        else begin @(negedge CLK); #1; end
      end
    end
  endtask

  task automatic clear_inputs();
    REQ0_VALID = 0; REQ0_FUN = 0; REQ0_A = 0; REQ0_B = 0;
    REQ1_VALID = 0; REQ1_FUN = 0; REQ1_A = 0; REQ1_B = 0;
    RSP_READY = 0;
  endtask

  task automatic apply_reset();
    @(negedge CLK);
    clear_inputs();
    RST = 0;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1;
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    RST = 0;
    @(negedge CLK); @(negedge CLK); #1;
    checks++;
    if (all_out !== 43'd0) begin errors++; $display("FAIL reset_outputs: got %h expected 0", all_out); end
    RST = 1;
    @(negedge CLK); #1;
    checks++;
    if (all_out !== 43'd0) begin errors++; $display("FAIL idle_outputs: got %h expected 0", all_out); end
    REQ0_VALID = 1; REQ1_VALID = 1; #1;
    checks++;
    if (rdys !== 2'b01) begin errors++; $display("FAIL first_tie: got %b expected 01", rdys); end
    REQ0_VALID = 0; REQ1_VALID = 0;
  endtask

  task automatic test_single_op();
    bit ok;
    @(negedge CLK);
    REQ0_VALID = 1; REQ0_FUN = 4'b1101; REQ0_A = 8'h81; REQ0_B = 8'h00; RSP_READY = 0; #1;
    checks++;
    if (rdys !== 2'b01) begin errors++; $display("FAIL single_ready: got %b expected 01", rdys); end
    @(negedge CLK); REQ0_VALID = 0; #1;
    checks++;
    if ({ens, ALU_FUN, ALU_A, RSP_VALID} !== {4'b0001, 2'b01, 8'h81, 1'b0}) begin
      errors++; $display("FAIL single_issue: got en=%b fun=%b a=%h v=%b expected en=0001 fun=01 a=81 v=0",
                         ens, ALU_FUN, ALU_A, RSP_VALID);
    end
    @(negedge CLK); #1;
    checks++;
    if ({ens, RSP_VALID} !== 5'b0) begin errors++; $display("FAIL single_wait: got en=%b v=%b expected 0", ens, RSP_VALID); end
    @(negedge CLK); #1;
    checks++;
    if ({RSP_VALID, RSP_DATA, RSP_ID, RSP_ERR} !== {1'b1, 16'h0102, 1'b0, 1'b0}) begin
      errors++; $display("FAIL single_rsp: got v=%b d=%h id=%b err=%b expected v=1 d=0102 id=0 err=0",
                         RSP_VALID, RSP_DATA, RSP_ID, RSP_ERR);
    end
    RSP_READY = 1;
    @(negedge CLK); #1;
    checks++;
    if (RSP_VALID !== 1'b0) begin errors++; $display("FAIL single_release: got %b expected 0", RSP_VALID); end
    RSP_READY = 0;
    ok = 1'b1;
  endtask

  task automatic test_round_robin();
    bit ok;
    logic [1:0] exp_rdy;
    apply_reset();
    REQ0_FUN = 4'b0000; REQ0_A = 8'h03; REQ0_B = 8'h04;
    REQ1_FUN = 4'b0100; REQ1_A = 8'hF0; REQ1_B = 8'h3C;
    REQ0_VALID = 1; REQ1_VALID = 1; RSP_READY = 1; #1;
    for (int i = 0; i < 4; i++) begin
      exp_rdy = (i % 2 == 1) ? 2'b10 : 2'b01;
      wait_accept(ok);
      checks++;
      if (!ok || rdys !== exp_rdy) begin errors++; $display("FAIL rr_grant%0d: got %b expected %b", i, rdys, exp_rdy); end
      wait_rsp(ok);
      checks++;
      if (!ok || RSP_ID !== 1'(i % 2) || RSP_DATA !== ((i % 2 == 1) ? 16'hA530 : 16'h0007)) begin
        errors++; $display("FAIL rr_rsp%0d: got ok=%b id=%b d=%h expected id=%0d d=%h", i, ok, RSP_ID, RSP_DATA,
                           i % 2, (i % 2 == 1) ? 16'hA530 : 16'h0007);
      end
      if (i == 3) begin REQ0_VALID = 0; REQ1_VALID = 0; end
      @(negedge CLK); #1;
    end
    RSP_READY = 0;
  endtask

  task automatic test_back_to_back();
    bit ok;
    @(negedge CLK);
    REQ1_VALID = 1; REQ1_FUN = 4'b0100; REQ1_A = 8'h0F; REQ1_B = 8'hFF; RSP_READY = 0; #1;
    wait_accept(ok);
    checks++;
    if (!ok || rdys !== 2'b10) begin errors++; $display("FAIL bp_accept: got %b expected 10", rdys); end
    @(negedge CLK); REQ1_VALID = 0; #1;
    wait_rsp(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_rsp_timeout: got no response expected RSP_VALID"); end
    REQ0_VALID = 1; REQ0_FUN = 4'b0000; REQ0_A = 8'h10; REQ0_B = 8'h20; #1;
    for (int j = 0; j < 5; j++) begin
      checks++;
      if ({RSP_VALID, RSP_ID, RSP_ERR, RSP_DATA, rdys} !== {1'b1, 1'b1, 1'b0, 16'hA50F, 2'b00}) begin
        errors++; $display("FAIL bp_hold%0d: got v=%b id=%b err=%b d=%h rdy=%b expected v=1 id=1 err=0 d=a50f rdy=00",
                           j, RSP_VALID, RSP_ID, RSP_ERR, RSP_DATA, rdys);
      end
      @(negedge CLK); #1;
    end
    RSP_READY = 1; #1;
    @(negedge CLK); #1;
    checks++;
    if ({RSP_VALID, rdys} !== 3'b001) begin errors++; $display("FAIL bp_idle: got v=%b rdy=%b expected v=0 rdy=01", RSP_VALID, rdys); end
    @(negedge CLK); REQ0_VALID = 0; #1;
    wait_rsp(ok);
    checks++;
    if (!ok || {RSP_ID, RSP_ERR, RSP_DATA} !== {1'b0, 1'b0, 16'h0030}) begin
      errors++; $display("FAIL bp_next: got ok=%b id=%b err=%b d=%h expected id=0 err=0 d=0030", ok, RSP_ID, RSP_ERR, RSP_DATA);
    end
    @(negedge CLK); RSP_READY = 0; #1;
  endtask

  task automatic test_timeout();
    bit ok;
    @(negedge CLK);
    fen_cmp = 0;
    REQ0_VALID = 1; REQ0_FUN = 4'b1000; REQ0_A = 8'h05; REQ0_B = 8'h09; RSP_READY = 0; #1;
    wait_accept(ok);
    checks++;
    if (!ok || rdys !== 2'b01) begin errors++; $display("FAIL to_accept: got %b expected 01", rdys); end
    @(negedge CLK); REQ0_VALID = 0; #1;
    checks++;
    if (ens !== 4'b0010) begin errors++; $display("FAIL to_issue: got %b expected 0010", ens); end
    for (int w = 0; w < 4; w++) begin
      @(negedge CLK); noise_ar = 1; #1;
      checks++;
      if ({RSP_VALID, ens, ALU_A} !== {1'b0, 4'b0000, 8'h05}) begin
        errors++; $display("FAIL to_wait%0d: got v=%b en=%b a=%h expected v=0 en=0000 a=05", w, RSP_VALID, ens, ALU_A);
      end
    end
    @(negedge CLK); noise_ar = 0; #1;
    checks++;
    if ({RSP_VALID, RSP_ERR, RSP_DATA, RSP_ID} !== {1'b1, 1'b1, 16'h0000, 1'b0}) begin
      errors++; $display("FAIL to_rsp: got v=%b err=%b d=%h id=%b expected v=1 err=1 d=0000 id=0",
                         RSP_VALID, RSP_ERR, RSP_DATA, RSP_ID);
    end
    RSP_READY = 1;
    @(negedge CLK); RSP_READY = 0; fen_cmp = 1; #1;
  endtask

  task automatic test_reset_mid_wait();
    bit ok;
    @(negedge CLK);
    fen_cmp = 0;
    REQ0_VALID = 1; REQ0_FUN = 4'b1000; REQ0_A = 8'h01; REQ0_B = 8'h02; #1;
    wait_accept(ok);
    checks++;
    if (!ok || rdys !== 2'b01) begin errors++; $display("FAIL rmw_accept: got %b expected 01", rdys); end
    @(negedge CLK); REQ0_VALID = 0;
    @(negedge CLK); RST = 0; #1;
    checks++;
    if (all_out !== 43'd0) begin errors++; $display("FAIL rmw_outputs: got %h expected 0", all_out); end
    @(negedge CLK); RST = 1; fen_cmp = 1;
    REQ0_VALID = 1; REQ0_FUN = 4'b0000; REQ0_A = 8'h01; REQ0_B = 8'h02;
    REQ1_VALID = 1; REQ1_FUN = 4'b0100; REQ1_A = 8'hFF; REQ1_B = 8'h0F; #1;
    checks++;
    if (rdys !== 2'b01) begin errors++; $display("FAIL rmw_tie: got %b expected 01", rdys); end
    @(negedge CLK); REQ0_VALID = 0; REQ1_VALID = 0; RSP_READY = 1; #1;
    wait_rsp(ok);
    checks++;
    if (!ok || {RSP_ID, RSP_ERR, RSP_DATA} !== {1'b0, 1'b0, 16'h0003}) begin
      errors++; $display("FAIL rmw_rsp: got ok=%b id=%b err=%b d=%h expected id=0 err=0 d=0003", ok, RSP_ID, RSP_ERR, RSP_DATA);
    end
    @(negedge CLK); RSP_READY = 0; #1;
  endtask

  task automatic test_enable_exclusive();
    bit ok;
    bit r;
    logic [3:0]  fun;
    logic [7:0]  a, b;
    logic [15:0] exp;
    RSP_READY = 1;
    for (int k = 0; k < 200; k++) begin
      @(negedge CLK);
      r = 1'($urandom_range(0, 1));
      fun = 4'($urandom); a = 8'($urandom); b = 8'($urandom);
      case (fun[3:2])
        2'd0:    exp = {8'h00, a} + {8'h00, b};
        2'd1:    exp = {8'hA5, a & b};
        2'd2:    exp = {15'd0, a < b};
        default: exp = {8'h00, a} << 1;
      endcase
      if (r) begin REQ1_VALID = 1; REQ1_FUN = fun; REQ1_A = a; REQ1_B = b; end
      else   begin REQ0_VALID = 1; REQ0_FUN = fun; REQ0_A = a; REQ0_B = b; end
      #1;
      wait_accept(ok);
      checks++;
      if (!ok || rdys !== (r ? 2'b10 : 2'b01)) begin errors++; $display("FAIL ex_accept%0d: got %b for requester %0d", k, rdys, r); end
      @(negedge CLK); REQ0_VALID = 0; REQ1_VALID = 0; #1;
      checks++;
      if ({ens, ALU_FUN} !== {4'b1000 >> fun[3:2], fun[1:0]}) begin
        errors++; $display("FAIL ex_issue%0d: got en=%b fun=%b expected en=%b fun=%b", k, ens, ALU_FUN, 4'b1000 >> fun[3:2], fun[1:0]);
      end
      @(negedge CLK); #1;
      checks++;
      if (ens !== 4'b0000) begin errors++; $display("FAIL ex_off%0d: got %b expected 0000", k, ens); end
      wait_rsp(ok);
      checks++;
      if (!ok || {RSP_ID, RSP_ERR, RSP_DATA} !== {r, 1'b0, exp}) begin
        errors++; $display("FAIL ex_rsp%0d: got ok=%b id=%b err=%b d=%h expected id=%b err=0 d=%h", k, ok, RSP_ID, RSP_ERR, RSP_DATA, r, exp);
      end
    end
    @(negedge CLK); RSP_READY = 0;
  endtask

  initial begin
    clear_inputs();
    RST = 0;
    test_reset();
    test_single_op();
    test_round_robin();
    test_back_to_back();
    test_timeout();
    test_reset_mid_wait();
    test_enable_exclusive();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
